// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared constants and FSM state encoding for the round-robin grant arbiter.
package decoder_rr_arbiter_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;
endpackage

// File: rtl/decoder_3_8.sv
// 3-to-8 decoder with enable; all outputs low when E is low.
module decoder_3_8 (
  input  logic       E,
  input  logic [2:0] In,
  output logic [7:0] Out
);
  // one-hot select of the addressed output
  always_comb begin
    Out = '0;
    if (E) Out[In] = 1'b1;
  end
endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 8 agents sharing one decoded one-hot resource.
// A grant is held until done, implicit release (req drops) or hold timeout,
// followed by a single dead cycle before the next owner is selected.
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [N_REQ-1:0] w_elig;
  logic [IDX_W:0]   w_pick;
  logic             w_hit_lim;
  logic             w_rel;

  // First eligible agent after p, wrapping; MSB of the result flags a hit.
  // Scanning from the farthest offset down lets the nearest one win.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] e,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] c;
    rr_pick = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      c = p + IDX_W'(i);
      if (e[c]) rr_pick = {1'b1, c};
    end
  endfunction

  assign w_elig    = req & {N_REQ{enable}};
  assign w_pick    = rr_pick(w_elig, r_ptr);
  assign w_hit_lim = (HOLD_MAX != 0) && (r_cnt == CNT_LAST);
  assign w_rel     = done || !req[r_idx] || w_hit_lim;

  // state and grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_ptr     <= IDX_W'(N_REQ - 1);
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // next-state: pick winner from IDLE/RELEASE, hold or release in GRANT
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_ptr_nxt     = r_ptr;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      ST_GRANT: begin
        if (w_rel) begin
          w_state_nxt   = ST_RELEASE;
          w_valid_nxt   = 1'b0;
          // flag only a release forced purely by the hold limit
          w_timeout_nxt = w_hit_lim && !done && req[r_idx];
        end else if (r_cnt != CNT_SAT) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin // ST_IDLE, ST_RELEASE
        if (w_pick[IDX_W]) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_pick[IDX_W-1:0];
          w_ptr_nxt   = w_pick[IDX_W-1:0];
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  decoder_3_8 u_dec (
    .E  (r_valid),
    .In (r_idx),
    .Out(gnt)
  );

  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench: stimulus queues expected grants, a negedge monitor checks them.
module tb_decoder_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  // len/gap of 0 mean "not checked"
  typedef struct {
    int idx;
    int len;
    bit to;
    int gap;
  } exp_t;
  exp_t sb[$];

  decoder_rr_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic expect_g(input int idx, input int len, input bit to, input int gap);
    exp_t e;
    e.idx = idx; e.len = len; e.to = to; e.gap = gap;
    sb.push_back(e);
  endtask

  // monitor: match each grant episode against the scoreboard
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   m_prev   = 1'b0;
  int   m_len    = 0;
  int   m_gap    = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (gnt_valid && !m_prev) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_grant: got idx=%0d want none", gnt_idx);
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          chk("grant_idx", 32'(gnt_idx), 32'(cur.idx));
          chk("grant_onehot", 32'(gnt), 32'(8'h01 << cur.idx));
          if (cur.gap != 0) chk("grant_gap", 32'(m_gap), 32'(cur.gap));
        end
        m_len = 0;
        m_gap = 0;
      end
      if (gnt_valid) begin
        m_len++;
      end else begin
        m_gap++;
        if (m_prev && have_cur) begin
          if (cur.len != 0) chk("grant_len", 32'(m_len), 32'(cur.len));
          chk("release_timeout", 32'(timeout), 32'(cur.to));
          have_cur = 1'b0;
        end
      end
      if (timeout && !(m_prev && !gnt_valid)) begin
        total++; bad++;
        $display("FAIL timeout_pulse: got=1 want=0");
      end
      if (gnt !== (gnt_valid ? (8'h01 << gnt_idx) : 8'h00)) begin
        total++; bad++;
        $display("FAIL gnt_consistency: got=%0h valid=%0b idx=%0d", gnt, gnt_valid, gnt_idx);
      end
      m_prev = gnt_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    // 1: reset state with all requests asserted
    rst_n = 1'b0; req = 8'hFF; enable = 1'b1; done = 1'b0;
    #12;
    chk("rst_gnt", 32'(gnt), 32'h00);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_idx", 32'(gnt_idx), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    req = 8'h00;
    rst_n = 1'b1;
    tick();

    // 2: single requester, done, regrant after one dead cycle
    req = 8'h04;
    expect_g(2, 1, 1'b0, 0);
    tick();
    pulse_done();
    expect_g(2, 1, 1'b0, 1);
    tick();
    pulse_done();
    req = 8'h00;
    tick();

    // 3: all requesting from reset pointer -> 0..7 then wrap to 0
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) expect_g(i % 8, 1, 1'b0, (i == 0) ? 0 : 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      pulse_done();
      tick();
    end
    pulse_done();
    req = 8'h00;
    tick();

    // 4: after grant 6, requests {6,0} -> 0 then 6
    req = 8'h40;
    expect_g(6, 1, 1'b0, 0);
    expect_g(0, 1, 1'b0, 1);
    expect_g(6, 1, 1'b0, 1);
    tick();
    req = 8'h41;
    pulse_done();
    tick();
    pulse_done();
    tick();
    pulse_done();
    req = 8'h00;
    tick();

    // 5: hold-limit timeout, regrant, then enable low blocks new grants
    req = 8'h02;
    expect_g(1, 4, 1'b1, 0);
    expect_g(1, 4, 1'b1, 1);
    tick();
    repeat (4) tick();
    tick();
    enable = 1'b0;
    repeat (4) tick();
    repeat (4) tick();
    chk("disabled_gnt", 32'(gnt), 32'h00);
    chk("disabled_valid", 32'(gnt_valid), 32'h0);
    req = 8'h00;
    enable = 1'b1;
    tick();

    // 6: async reset mid-grant, then pointer back at 7
    req = 8'h80;
    expect_g(7, 0, 1'b0, 0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h00);
    chk("async_rst_valid", 32'(gnt_valid), 32'h0);
    rst_n = 1'b1;
    req = 8'h81;
    expect_g(0, 1, 1'b0, 0);
    expect_g(7, 1, 1'b0, 1);
    tick();
    pulse_done();
    tick();
    pulse_done();
    req = 8'h00;
    repeat (3) tick();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
